// File: rtl/ondra_sram_arbiter.sv
// Shares the single external SRAM between video fetch, Z80 bus and background loader (video > CPU > loader, loader starvation guard).
// Latency: request sampled in IDLE at edge k -> one-cycle ack during cycle k+ACC_CYCLES+2; setup/strobe/hold per access.
// Backpressure: requests are levels held until their ack; losing requesters simply wait, no request is ever dropped.
module ondra_sram_arbiter #(
  parameter int unsigned ACC_CYCLES = 2,
  parameter int unsigned STARVE_MAX = 8,
  parameter logic [4:0]  BANK       = 5'd0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [15:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ldr_ack,
  output logic [7:0]  ldr_rdata,
  output logic [20:0] sram_addr,
  output logic [7:0]  sram_dout,
  output logic        sram_oe,
  input  logic [7:0]  sram_din,
  output logic        sram_we_n,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_HOLD} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_LDR  = 2'd3;

  localparam logic [2:0] STROBE_LAST = 3'(ACC_CYCLES - 1);
  localparam logic [3:0] STARVE_LIM  = 4'(STARVE_MAX);

  state_t      state, state_nx;
  logic [1:0]  owner;
  logic        we_q;
  logic [20:0] addr_q;
  logic [7:0]  wdata_q;
  logic [2:0]  strobe_cnt;
  logic [3:0]  starve_cnt;

  logic        arb_en;
  logic        vid_elig, cpu_elig, ldr_elig;
  logic [1:0]  win;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [7:0]  sel_wdata;

  // Pick the winner; in HOLD the owner's request is still up during its ack, so it is masked.
  always_comb begin
    arb_en   = (state == S_IDLE) || (state == S_HOLD);
    vid_elig = vid_req && arb_en && !((state == S_HOLD) && (owner == OWN_VID));
    cpu_elig = cpu_req && arb_en && !((state == S_HOLD) && (owner == OWN_CPU));
    ldr_elig = ldr_req && arb_en && !((state == S_HOLD) && (owner == OWN_LDR));
    win = OWN_NONE;
    if (vid_elig)                                   win = OWN_VID;
    else if (ldr_elig && (starve_cnt == STARVE_LIM)) win = OWN_LDR;
    else if (cpu_elig)                              win = OWN_CPU;
    else if (ldr_elig)                              win = OWN_LDR;
  end

  // Request fields of the winner, captured on the edge into ADDR.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = vid_addr;
    sel_wdata = 8'h00;
    if (win == OWN_CPU) begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end else if (win == OWN_LDR) begin
      sel_we    = ldr_we;
      sel_addr  = ldr_addr;
      sel_wdata = ldr_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next state plus strobe/ack/status outputs, all decoded from registered state.
  always_comb begin
    state_nx = state;
    vid_ack  = 1'b0;
    cpu_ack  = 1'b0;
    ldr_ack  = 1'b0;
    case (state)
      S_IDLE:   if (win != OWN_NONE) state_nx = S_ADDR;
      S_ADDR:   state_nx = S_STROBE;
      S_STROBE: if (strobe_cnt == STROBE_LAST) state_nx = S_HOLD;
      S_HOLD: begin
        vid_ack  = (owner == OWN_VID);
        cpu_ack  = (owner == OWN_CPU);
        ldr_ack  = (owner == OWN_LDR);
        state_nx = (win != OWN_NONE) ? S_ADDR : S_IDLE;
      end
      default:  state_nx = S_IDLE;
    endcase
    busy      = (state != S_IDLE);
    grant     = (state == S_IDLE) ? OWN_NONE : owner;
    sram_oe   = we_q && (state != S_IDLE);
    sram_we_n = !((state == S_STROBE) && we_q);
    sram_addr = addr_q;
    sram_dout = wdata_q;
  end

  // Latch owner and request fields so the bus stays stable while the requester changes its inputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      owner   <= OWN_NONE;
      we_q    <= 1'b0;
      addr_q  <= 21'd0;
      wdata_q <= 8'd0;
    end else if (state_nx == S_ADDR) begin
      owner   <= win;
      we_q    <= sel_we;
      addr_q  <= {BANK, sel_addr};
      wdata_q <= sel_wdata;
    end
  end

  // Count strobe cycles of the current access.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                 strobe_cnt <= 3'd0;
    else if (state == S_STROBE)   strobe_cnt <= strobe_cnt + 3'd1;
    else                          strobe_cnt <= 3'd0;
  end

  // Capture read data on the edge closing the last strobe cycle; it stays until that owner's next read.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vid_rdata <= 8'd0;
      cpu_rdata <= 8'd0;
      ldr_rdata <= 8'd0;
    end else if ((state == S_STROBE) && (strobe_cnt == STROBE_LAST) && !we_q) begin
      if (owner == OWN_VID) vid_rdata <= sram_din;
      if (owner == OWN_CPU) cpu_rdata <= sram_din;
      if (owner == OWN_LDR) ldr_rdata <= sram_din;
    end
  end

  // Count CPU wins over a waiting loader; video wins leave it alone.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
    end else if (arb_en) begin
      if (!ldr_elig || (win == OWN_LDR))
        starve_cnt <= 4'd0;
      else if ((win == OWN_CPU) && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_ondra_sram_arbiter.sv
// Bench for ondra_sram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: checks outputs 1 time unit after each rising clk_sys edge.
// Backpressure: bench masters hold each request until its ack, then drop or reissue at random.
module tb_ondra_sram_arbiter;

  localparam int         ACC  = 2;
  localparam int         SMAX = 8;
  localparam logic [4:0] BK   = 5'd0;
  localparam logic [4:0] BK2  = 5'h13;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        vid_req, vid_ack, cpu_req, cpu_we, cpu_ack, ldr_req, ldr_we, ldr_ack;
  logic [15:0] vid_addr, cpu_addr, ldr_addr;
  logic [7:0]  vid_rdata, cpu_wdata, cpu_rdata, ldr_wdata, ldr_rdata;
  logic [20:0] sram_addr;
  logic [7:0]  sram_dout, sram_din;
  logic        sram_oe, sram_we_n, busy;
  logic [1:0]  grant;

  // second instance: ACC_CYCLES = 1, nonzero bank, video only
  logic        v2_req, v2_ack, c2_ack, l2_ack, s2_oe, s2_we_n, busy2;
  logic [15:0] v2_addr;
  logic [7:0]  v2_rdata, c2_rdata, l2_rdata, s2_dout, s2_din;
  logic [20:0] s2_addr;
  logic [1:0]  grant2;

  int n_tests = 0;
  int n_fail  = 0;

  ondra_sram_arbiter #(.ACC_CYCLES(ACC), .STARVE_MAX(SMAX), .BANK(BK)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_oe(sram_oe), .sram_din(sram_din),
    .sram_we_n(sram_we_n), .grant(grant), .busy(busy)
  );

  ondra_sram_arbiter #(.ACC_CYCLES(1), .STARVE_MAX(SMAX), .BANK(BK2)) dut2 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .vid_req(v2_req), .vid_addr(v2_addr), .vid_ack(v2_ack), .vid_rdata(v2_rdata),
    .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(16'h0000), .cpu_wdata(8'h00),
    .cpu_ack(c2_ack), .cpu_rdata(c2_rdata),
    .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(16'h0000), .ldr_wdata(8'h00),
    .ldr_ack(l2_ack), .ldr_rdata(l2_rdata),
    .sram_addr(s2_addr), .sram_dout(s2_dout), .sram_oe(s2_oe), .sram_din(s2_din),
    .sram_we_n(s2_we_n), .grant(grant2), .busy(busy2)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hB8;
  endfunction

  // behavioural SRAM: 64 KB, write on any clock edge seen with the strobe low
  logic [7:0] tb_mem [0:65535];
  assign sram_din = tb_mem[sram_addr[15:0]];
  assign s2_din   = s2_addr[7:0] ^ 8'h5A;

  initial begin
    for (int i = 0; i < 65536; i++) tb_mem[i] = pat(16'(i));
    forever begin
      @(posedge clk_sys);
      if (!sram_we_n) tb_mem[sram_addr[15:0]] = sram_dout;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // random-phase master state, indexed 1 = video, 2 = CPU, 3 = loader
  logic        m_pend  [1:3];
  logic        m_we    [1:3];
  logic [15:0] m_addr  [1:3];
  logic [7:0]  m_wdata [1:3];
  logic [7:0]  ref_mem [0:65535];

  task automatic new_req(input int r);
    m_pend[r]  = 1'b1;
    m_we[r]    = (r == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    m_addr[r]  = 16'($urandom_range(0, 31)) | (($urandom_range(0, 3) == 0) ? 16'hC000 : 16'h0000);
    m_wdata[r] = 8'($urandom);
  endtask

  task automatic drive_masters();
    vid_req = m_pend[1]; vid_addr = m_addr[1];
    cpu_req = m_pend[2]; cpu_we = m_we[2]; cpu_addr = m_addr[2]; cpu_wdata = m_wdata[2];
    ldr_req = m_pend[3]; ldr_we = m_we[3]; ldr_addr = m_addr[3]; ldr_wdata = m_wdata[3];
  endtask

  initial begin
    int oe_cnt, wen_cnt, ack_cnt, cpu_wins, ldr_grants;
    int seen [0:1];
    logic [15:0] a_hist [0:40];
    logic [7:0]  exp_rd [1:3];
    logic        acks   [1:3];
    logic        mod_has, mod_we, in_txn, arb;
    logic [1:0]  mod_owner;
    logic [15:0] mod_addr;
    logic [7:0]  mod_wdata, mod_rval;
    int          mod_start, mod_ack, starve, w, p;
    logic        elig [1:3];

    vid_req = 1'b1; vid_addr = 16'hC123;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 16'h0; ldr_wdata = 8'h0;
    v2_req = 1'b0; v2_addr = 16'h0;

    // reset with a pending video request
    repeat (3) tick();
    check_eq("rst_vid_ack", vid_ack, 0);
    check_eq("rst_cpu_ack", cpu_ack, 0);
    check_eq("rst_ldr_ack", ldr_ack, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_we_n", sram_we_n, 1);
    check_eq("rst_oe", sram_oe, 0);
    check_eq("rst_addr", sram_addr, 0);
    check_eq("rst_dout", sram_dout, 0);
    check_eq("rst_rdata", {vid_rdata, cpu_rdata, ldr_rdata}, 0);

    // single video read; sampled at the first edge after release
    reset_n = 1'b1;
    tick();
    check_eq("vid_addr_out", sram_addr, 21'h0C123);
    check_eq("vid_grant", grant, 1);
    check_eq("vid_busy", busy, 1);
    tick(); check_eq("vid_ack_early1", vid_ack, 0);
    tick(); check_eq("vid_ack_early2", vid_ack, 0);
    tick();
    check_eq("vid_ack", vid_ack, 1);
    check_eq("vid_rdata", vid_rdata, 8'h5A);
    vid_req = 1'b0;
    tick();
    check_eq("vid_ack_once", vid_ack, 0);
    check_eq("vid_idle", busy, 0);
    check_eq("vid_rdata_hold", vid_rdata, 8'h5A);

    // CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 8'hA5;
    oe_cnt = 0; wen_cnt = 0; ack_cnt = 0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (sram_oe) begin
        oe_cnt++;
        check_eq("wr_dout", sram_dout, 8'hA5);
      end
      if (!sram_we_n) wen_cnt++;
      if (cpu_ack) begin ack_cnt++; cpu_req = 1'b0; cpu_we = 1'b0; end
    end
    check_eq("wr_oe_cycles", oe_cnt, 4);
    check_eq("wr_we_n_cycles", wen_cnt, 2);
    check_eq("wr_ack_count", ack_cnt, 1);
    check_eq("wr_rdata_kept", cpu_rdata, 0);
    check_eq("wr_mem", tb_mem[16'h4000], 8'hA5);

    // simultaneous requests from all three
    vid_req = 1'b1; vid_addr = 16'h0010;
    cpu_req = 1'b1; cpu_addr = 16'h0020;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0030;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 1)  check_eq("all3_grant_vid", grant, 1);
      if (t == 5)  check_eq("all3_grant_cpu", grant, 2);
      if (t == 9)  check_eq("all3_grant_ldr", grant, 3);
      if (t == 13) check_eq("all3_grant_none", grant, 0);
      check_eq("all3_vid_ack", vid_ack, (t == 4));
      check_eq("all3_cpu_ack", cpu_ack, (t == 8));
      check_eq("all3_ldr_ack", ldr_ack, (t == 12));
      if (vid_ack) vid_req = 1'b0;
      if (cpu_ack) cpu_req = 1'b0;
      if (ldr_ack) ldr_req = 1'b0;
    end
    check_eq("all3_ldr_rdata", ldr_rdata, pat(16'h0030));

    // starvation guard: video and CPU alternate forever, loader waits
    vid_req = 1'b1; cpu_req = 1'b1; ldr_req = 1'b1;
    cpu_wins = 0; ldr_grants = 0; seen[0] = -1; seen[1] = -1;
    for (int t = 0; t < 400 && ldr_grants < 2; t++) begin
      tick();
      if (cpu_ack) cpu_wins++;
      if (ldr_ack) begin
        seen[ldr_grants] = cpu_wins;
        ldr_grants++;
        cpu_wins = 0;
      end
    end
    check_eq("starve_ldr_grants", ldr_grants, 2);
    check_eq("starve_first", seen[0], SMAX);
    check_eq("starve_after_clear", seen[1], SMAX);
    vid_req = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (6) tick();
    check_eq("starve_idle", busy, 0);

    // reset in the middle of a write strobe
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4001; cpu_wdata = 8'h77;
    tick(); tick();
    check_eq("abort_in_strobe", sram_we_n, 0);
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    check_eq("abort_we_n", sram_we_n, 1);
    check_eq("abort_oe", sram_oe, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_grant", grant, 0);
    ack_cnt = 0;
    for (int t = 0; t < 3; t++) begin tick(); if (cpu_ack) ack_cnt++; end
    reset_n = 1'b1;
    for (int t = 0; t < 3; t++) begin tick(); if (cpu_ack) ack_cnt++; end
    check_eq("abort_no_ack", ack_cnt, 0);
    check_eq("abort_idle", busy, 0);
    check_eq("abort_mem", tb_mem[16'h4001], pat(16'h4001));

    // randomized traffic against the transaction model
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 65536; i++) ref_mem[i] = tb_mem[i];
    for (int r = 1; r <= 3; r++) begin
      m_pend[r] = 1'b0; m_we[r] = 1'b0; m_addr[r] = 16'h0; m_wdata[r] = 8'h0; exp_rd[r] = 8'h00;
    end
    drive_masters();
    mod_has = 1'b0; mod_owner = 2'd0; mod_we = 1'b0; mod_addr = 16'h0; mod_wdata = 8'h0;
    mod_rval = 8'h0; mod_start = 0; mod_ack = 0; starve = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      tick();
      in_txn = mod_has && (cyc <= mod_ack);
      if (in_txn && (cyc == mod_ack) && !mod_we) exp_rd[mod_owner] = mod_rval;
      check_eq("rnd_grant", grant, in_txn ? mod_owner : 2'd0);
      check_eq("rnd_busy", busy, in_txn);
      check_eq("rnd_vid_ack", vid_ack, in_txn && (cyc == mod_ack) && (mod_owner == 2'd1));
      check_eq("rnd_cpu_ack", cpu_ack, in_txn && (cyc == mod_ack) && (mod_owner == 2'd2));
      check_eq("rnd_ldr_ack", ldr_ack, in_txn && (cyc == mod_ack) && (mod_owner == 2'd3));
      check_eq("rnd_oe", sram_oe, in_txn && mod_we);
      check_eq("rnd_we_n", sram_we_n, !(in_txn && mod_we && (cyc > mod_start) && (cyc < mod_ack)));
      if (in_txn) check_eq("rnd_addr", sram_addr, {BK, mod_addr});
      if (in_txn && mod_we) check_eq("rnd_dout", sram_dout, mod_wdata);
      check_eq("rnd_vid_rdata", vid_rdata, exp_rd[1]);
      check_eq("rnd_cpu_rdata", cpu_rdata, exp_rd[2]);
      check_eq("rnd_ldr_rdata", ldr_rdata, exp_rd[3]);

      acks[1] = vid_ack; acks[2] = cpu_ack; acks[3] = ldr_ack;
      for (int r = 1; r <= 3; r++) begin
        if (m_pend[r] && acks[r]) begin
          if ($urandom_range(0, 1) == 1) new_req(r);
          else m_pend[r] = 1'b0;
        end else if (!m_pend[r] && ($urandom_range(0, 3) == 0)) begin
          new_req(r);
        end
      end
      drive_masters();

      // arbitration at the edge closing this cycle: when free, or in the ack cycle (owner excluded)
      arb = !in_txn || (cyc == mod_ack);
      if (arb) begin
        for (int r = 1; r <= 3; r++) elig[r] = m_pend[r] && !(in_txn && (int'(mod_owner) == r));
        if (elig[1])                         w = 1;
        else if (elig[3] && (starve == SMAX)) w = 3;
        else if (elig[2])                    w = 2;
        else if (elig[3])                    w = 3;
        else                                 w = 0;
        if (!elig[3] || (w == 3)) starve = 0;
        else if (w == 2)          starve = (starve < SMAX) ? starve + 1 : SMAX;
        if (w != 0) begin
          mod_has   = 1'b1;
          mod_owner = 2'(w);
          mod_we    = m_we[w];
          mod_addr  = m_addr[w];
          mod_wdata = m_wdata[w];
          mod_start = cyc + 1;
          mod_ack   = cyc + ACC + 2;
          if (mod_we) ref_mem[mod_addr] = mod_wdata;
          else        mod_rval = ref_mem[mod_addr];
        end else begin
          mod_has = 1'b0;
        end
      end
    end
    for (int r = 1; r <= 3; r++) m_pend[r] = 1'b0;
    drive_masters();

    // ACC_CYCLES = 1, video held high: the requester is masked in its own HOLD,
    // so each repeat goes HOLD -> IDLE -> ADDR, a 4-cycle period; address wiggles must not leak out
    v2_req  = 1'b1;
    v2_addr = 16'($urandom);
    a_hist[0] = v2_addr;
    for (int t = 1; t <= 24; t++) begin
      tick();
      p = (t - 1) % 4;
      if (p <= 2) check_eq("acc1_addr", s2_addr, {BK2, a_hist[t - 1 - p]});
      check_eq("acc1_ack", v2_ack, (p == 2));
      check_eq("acc1_busy", busy2, (p != 3));
      check_eq("acc1_grant", grant2, (p != 3) ? 2'd1 : 2'd0);
      if (p == 2) check_eq("acc1_rdata", v2_rdata, a_hist[t - 3][7:0] ^ 8'h5A);
      check_eq("acc1_no_write", {s2_oe, s2_we_n}, 2'b01);
      check_eq("acc1_other_acks", {c2_ack, l2_ack}, 2'b00);
      v2_addr   = 16'($urandom);
      a_hist[t] = v2_addr;
    end
    v2_req = 1'b0;
    check_eq("acc1_other_rdata", {c2_rdata, l2_rdata}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
